// File: rtl/elastic_pipe_pkg.sv
// elastic_pipe_pkg: shared defaults and sizing helper for the elastic pipe chain
package elastic_pipe_pkg;
  localparam int PIPE_DEFAULT_WIDTH = 32;
  localparam int PIPE_DEFAULT_DEPTH = 4;
  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/elastic_pipe_stage.sv
// elastic_pipe_stage: one valid/data slice; loads when empty or when downstream takes its beat
module elastic_pipe_stage
  import elastic_pipe_pkg::*;
#(
  parameter int WIDTH = PIPE_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  input  logic             dn_rdy,
  output logic             v,
  output logic [WIDTH-1:0] d,
  output logic             rdy
);
  assign rdy = !v || dn_rdy;
  // valid follows the source when ready, flush empties; data only moves with a real beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v <= 1'b0;
      d <= '0;
    end else begin
      v <= flush ? 1'b0 : (rdy ? up_valid : v);
      if (rdy && up_valid && !flush) d <= up_data;
    end
  end
endmodule

// File: rtl/elastic_pipe_chain.sv
// elastic_pipe_chain: DEPTH-stage valid/ready register pipe; ELASTIC_PIPE_OCC_EN adds an occupancy counter
module elastic_pipe_chain
  import elastic_pipe_pkg::*;
#(
  parameter int WIDTH = PIPE_DEFAULT_WIDTH,
  parameter int DEPTH = PIPE_DEFAULT_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef ELASTIC_PIPE_OCC_EN
  ,
  output logic [occ_width(DEPTH)-1:0] occupancy
`endif
);
  logic [DEPTH:0]   rdy;
  logic [DEPTH-1:0] v;
  logic [WIDTH-1:0] d [DEPTH];
  assign rdy[DEPTH] = out_ready;
  assign in_ready   = rdy[0] && !flush;
  assign out_valid  = v[DEPTH-1];
  assign out_data   = d[DEPTH-1];
  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic             src_v;
    logic [WIDTH-1:0] src_d;
    if (i == 0) begin : g_head
      assign src_v = in_valid;
      assign src_d = in_data;
    end else begin : g_body
      assign src_v = v[i-1];
      assign src_d = d[i-1];
    end
    elastic_pipe_stage #(.WIDTH(WIDTH)) u_stage (
      .clk     (clk),
      .rst     (rst),
      .flush   (flush),
      .up_valid(src_v),
      .up_data (src_d),
      .dn_rdy  (rdy[i+1]),
      .v       (v[i]),
      .d       (d[i]),
      .rdy     (rdy[i])
    );
  end
`ifdef ELASTIC_PIPE_OCC_EN
  logic acc, dlv;
  assign acc = in_valid && in_ready;
  assign dlv = out_valid && out_ready;
  // beats held: up on accept, down on deliver, cleared by flush
  always_ff @(posedge clk or posedge rst) begin
    if (rst) occupancy <= '0;
    else occupancy <= flush ? '0 : (acc && !dlv) ? occupancy + 1'b1 : (dlv && !acc) ? occupancy - 1'b1 : occupancy;
  end
`endif
endmodule

// File: tb/tb_elastic_pipe_chain.sv
// tb_elastic_pipe_chain: directed scoreboard bench for elastic_pipe_chain (WIDTH=32, DEPTH=4)
module tb_elastic_pipe_chain;
  logic        clk, rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_data, out_data;
`ifdef ELASTIC_PIPE_OCC_EN
  logic [2:0]  occupancy;
`endif
  logic [31:0] sb [$];
  int          n_cmp = 0, n_err = 0, n_deliv = 0;

  elastic_pipe_chain #(.WIDTH(32), .DEPTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
`ifdef ELASTIC_PIPE_OCC_EN
    ,
    .occupancy(occupancy)
`endif
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_occ(input string nm, input logic [31:0] exp);
`ifdef ELASTIC_PIPE_OCC_EN
    chk(nm, {29'd0, occupancy}, exp);
`endif
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] val);
    int i = 0;
    in_valid = 1'b1;
    in_data  = val;
    while (!in_ready && i < 50) begin
      step();
      i++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL push_timeout: in_ready %b expected 1 for %h", in_ready, val);
    end
    step();
    in_valid = 1'b0;
  endtask

  // mid-cycle monitor: handshakes seen here complete at the next rising edge
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        n_deliv++;
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL deliver_unexpected: got %h expected no beat", out_data);
        end else chk("deliver", out_data, sb.pop_front());
      end
      if (flush) sb.delete();
      else if (in_valid && in_ready) sb.push_back(in_data);
    end
  end

  initial begin
    int d0;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_in_ready", {31'd0, in_ready}, 1);
    chk_occ("rst_occ", 0);
    // single beat latency and hold under backpressure
    in_valid = 1'b1; in_data = 32'hABCC_1111;
    step();
    in_valid = 1'b0;
    chk("lat_e0", {31'd0, out_valid}, 0);
    step(); chk("lat_e1", {31'd0, out_valid}, 0);
    step(); chk("lat_e2", {31'd0, out_valid}, 0);
    step(); chk("lat_e3", {31'd0, out_valid}, 1);
    chk("lat_data", out_data, 32'hABCC_1111);
    repeat (3) step();
    chk("hold_valid", {31'd0, out_valid}, 1);
    chk("hold_data", out_data, 32'hABCC_1111);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("pop_empty", {31'd0, out_valid}, 0);
    chk("empty_keeps_data", out_data, 32'hABCC_1111);
    // fill to capacity
    for (int k = 1; k <= 4; k++) push(k);
    in_valid = 1'b1; in_data = 32'h5;
    #1;
    chk("full_in_ready", {31'd0, in_ready}, 0);
    chk_occ("full_occ", 4);
    out_ready = 1'b1;
    #1;
    chk("full_pushpop_ready", {31'd0, in_ready}, 1);
    step();
    in_valid = 1'b0;
    chk_occ("full_pushpop_occ", 4);
    repeat (6) step();
    chk("bp_drained", sb.size(), 0);
    chk("bp_empty", {31'd0, out_valid}, 0);
    chk_occ("bp_occ", 0);
    // streaming at full rate
    d0 = n_deliv;
    in_valid = 1'b1;
    for (int n = 0; n < 12; n++) begin
      in_data = 32'h0CCA_3333 + n;
      step();
      if (n == 2) chk("stream_latency", {31'd0, out_valid}, 0);
      if (n >= 3) begin
        chk("stream_valid", {31'd0, out_valid}, 1);
        chk("stream_in_ready", {31'd0, in_ready}, 1);
        chk_occ("stream_occ", 4);
      end
    end
    in_valid = 1'b0;
    chk("stream_rate", n_deliv - d0, 8);
    repeat (6) step();
    chk("stream_drained", sb.size(), 0);
    // flush with three beats held
    out_ready = 1'b0;
    push(32'hA0); push(32'hB0); push(32'hC0);
    chk_occ("pre_flush_occ", 3);
    flush = 1'b1; in_valid = 1'b1; in_data = 32'hDEAD_BEEF;
    #1;
    chk("flush_in_ready", {31'd0, in_ready}, 0);
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_valid", {31'd0, out_valid}, 0);
    chk_occ("flush_occ", 0);
    push(32'hD00D_0001);
    out_ready = 1'b1;
    repeat (6) step();
    chk("flush_first_out", out_data, 32'hD00D_0001);
    chk("flush_drained", sb.size(), 0);
    // asynchronous reset pulse mid-stream
    in_valid = 1'b1;
    for (int n = 0; n < 6; n++) begin
      in_data = 32'h5000 + n;
      step();
    end
    #1 rst = 1'b1;
    #1;
    chk("arst_out_valid", {31'd0, out_valid}, 0);
    chk("arst_out_data", out_data, 0);
    chk("arst_in_ready", {31'd0, in_ready}, 1);
    chk_occ("arst_occ", 0);
    sb.delete();
    #2 rst = 1'b0;
    for (int n = 6; n < 12; n++) begin
      in_data = 32'h5000 + n;
      step();
    end
    in_valid = 1'b0;
    repeat (6) step();
    chk("arst_drained", sb.size(), 0);
    chk("arst_last", out_data, 32'h500B);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
